ysyx_220066_if: RTL

Instruction-fetch stage of the ysyx_220066 pipeline, directly upstream of the decode stage. Issues sequential 4-byte fetches to the instruction memory, buffers returned words with their PCs in a small FIFO, and presents one {pc, instr} pair per cycle to decode under a valid/ready handshake. Handles pipeline redirects by flushing buffered and in-flight fetches.

---
 rtl/ysyx_220066_pkg.sv | 15 +
 rtl/ysyx_220066_if_fifo.sv | 47 ++++
 rtl/ysyx_220066_if.sv | 103 ++++++++++
 3 files changed

// File: rtl/ysyx_220066_pkg.sv
// ysyx_220066_pkg: shared constants and types for the ysyx_220066 instruction-fetch stage
//   RESET_PC_DEFAULT - first fetch address after reset
//   NOP              - word presented in place of a faulting fetch
//   if_state_t       - fetch control state
//   if_entry_t       - one buffered {pc, instr, err} record (97 bits)
package ysyx_220066_pkg;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic {FETCH, HALT} if_state_t;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        err;
  } if_entry_t;
endpackage

// File: rtl/ysyx_220066_if_fifo.sv
// ysyx_220066_if_fifo: DEPTH-entry buffer of fetched {pc, instr, err} records
//   clk, rst      - clock, asynchronous active-low reset
//   flush_i       - empty the buffer; a simultaneous push becomes the only entry
//   push_i/din_i  - write one entry
//   pop_i/dout_o  - head entry, removed on pop_i (push+pop when full is allowed)
//   count_o, full_o, empty_o - occupancy
module ysyx_220066_if_fifo import ysyx_220066_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  if_entry_t               din_i,
  output if_entry_t               dout_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);
  localparam int AW = $clog2(DEPTH);
  if_entry_t     mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [AW:0]   cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      if (push_i) mem_q[0] <= din_i;
      rd_q  <= '0;
      wr_q  <= AW'(push_i);
      cnt_q <= (AW+1)'(push_i);
    end else begin
      if (push_i) mem_q[wr_q] <= din_i;
      rd_q  <= rd_q + AW'(pop_i);
      wr_q  <= wr_q + AW'(push_i);
      cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
    end
  end
endmodule

// File: rtl/ysyx_220066_if.sv
// ysyx_220066_if: instruction-fetch stage; issues sequential fetches, buffers words, hands {pc, instr} to decode
//   clk, rst                  - clock, asynchronous active-low reset
//   imem_req_valid/ready/addr - fetch request channel (4-byte aligned)
//   imem_resp_valid/data/err  - in-order fetch responses, err marks an access fault
//   redirect_valid/pc         - flush everything and restart fetch at redirect_pc
//   valid/ready               - decode handshake
//   pc, instr, fetch_err      - presented entry; fetch_err marks misaligned or faulting fetch
module ysyx_220066_if import ysyx_220066_pkg::*; #(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        valid,
  input  logic        ready,
  output logic [63:0] pc,
  output logic [31:0] instr,
  output logic        fetch_err
);
  localparam int CW = $clog2(DEPTH) + 1;
  if_state_t   state_q, state_d;
  logic [63:0] fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d;
  logic [CW-1:0] out_q, out_d, drop_q, drop_d, fifo_cnt;
  logic [CW:0] credit;
  logic        fifo_full, fifo_empty, push, pop, fire, misalign;
  if_entry_t   push_e, head;
  ysyx_220066_if_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (push_e),
    .dout_o  (head),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
  assign valid     = !fifo_empty && !redirect_valid;
  assign pop       = valid && ready;
  assign pc        = head.pc;
  assign instr     = head.instr;
  assign fetch_err = head.err;
  assign misalign  = redirect_pc[1:0] != 2'b00;
  // An entry leaving this cycle frees its slot in time for a new fetch, which keeps
  // one instruction per cycle flowing with a 1-cycle memory. In-flight fetches that
  // will be dropped still hold credit, so the FIFO can never overflow.
  assign credit         = {1'b0, out_q} + {1'b0, fifo_cnt} - (CW+1)'(pop);
  assign imem_req_valid = rst && state_q == FETCH && !redirect_valid && credit < (CW+1)'(DEPTH);
  assign imem_addr      = fetch_pc_q;
  assign fire           = imem_req_valid && imem_req_ready;
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    drop_d     = drop_q;
    out_d      = out_q + CW'(fire) - CW'(imem_resp_valid);
    push       = 1'b0;
    push_e     = '{pc: resp_pc_q, instr: imem_resp_err ? NOP : imem_resp_data, err: imem_resp_err};
    if (redirect_valid) begin
      // every fetch still in flight belongs to the old path, including one answering now
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_d     = out_q - CW'(imem_resp_valid);
      push       = misalign;
      push_e     = '{pc: redirect_pc, instr: NOP, err: 1'b1};
      state_d    = misalign ? HALT : FETCH;
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + 64'd4;
      if (imem_resp_valid && drop_q != '0) drop_d = drop_q - CW'(1);
      if (imem_resp_valid && drop_q == '0) begin
        push      = 1'b1;
        resp_pc_d = resp_pc_q + 64'd4;
        state_d   = imem_resp_err ? HALT : state_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
    end
  end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(imem_resp_valid && !redirect_valid && drop_q == '0 && fifo_full));
endmodule
